bus_arbiter_3: RTL

Round-robin arbiter and sequencer for the shared 16-bit datapath bus driven by the 3-input bus multiplexer. Three requesters (0, 1, 2) each drive one mux data input. The arbiter grants the bus to one requester at a time and drives the mux select. It enforces a maximum tenure so no requester can starve the others, and hands the bus directly between requesters with no idle gap.

---
 rtl/bus_arbiter_3_if.sv | 20 ++
 rtl/bus_arbiter_3.sv | 92 +++++++++
 2 files changed

// File: rtl/bus_arbiter_3_if.sv
// Bus-arbiter request/grant bundle between the three requesters and the arbiter.
// The arbiter takes the slave view; the requester side (or a bench) takes master.
interface bus_arbiter_3_if;
  logic [2:0] req_in;
  logic [2:0] last_in;
  logic [2:0] grant_out;
  logic [1:0] sel_out;
  logic       busy_out;
  logic       preempt_out;

  modport master (
    output req_in, last_in,
    input  grant_out, sel_out, busy_out, preempt_out
  );

  modport slave (
    input  req_in, last_in,
    output grant_out, sel_out, busy_out, preempt_out
  );
endinterface

// File: rtl/bus_arbiter_3.sv
// Round-robin arbiter for the 3-input 16-bit bus mux, with a bounded tenure and
// zero-gap handover between owners. All outputs are registered.
module bus_arbiter_3 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_arbiter_3_if.slave  bus
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [2:0] grant_q, grant_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic       busy_q, pre_q, pre_nxt;

  logic [1:0] cand1, cand2, win;
  logic       any_req, own_req, own_last, timeout, end_ten;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : 2'(x + 2'd1);
  endfunction

  // ptr is the most recent owner, so it is searched last.
  always_comb begin
    cand1   = inc3(ptr);
    cand2   = inc3(cand1);
    any_req = |bus.req_in;
    if (bus.req_in[cand1])      win = cand1;
    else if (bus.req_in[cand2]) win = cand2;
    else                        win = ptr;
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    pre_nxt   = 1'b0;
    own_req   = bus.req_in[ptr];
    own_last  = bus.last_in[ptr];
    timeout   = (hold_cnt == HOLD_LAST);
    end_ten   = (state == IDLE) || !own_req || own_last || timeout;

    if (!end_ten) begin
      hold_nxt = 8'(hold_cnt + 8'd1);
    end else begin
      // Preempt only when the timeout alone ended a still-active tenure.
      pre_nxt  = (state == OWNED) && own_req && !own_last && timeout;
      hold_nxt = 8'd0;
      if (any_req) begin
        state_nxt = OWNED;
        ptr_nxt   = win;
      end else begin
        state_nxt = IDLE;
      end
    end

    grant_nxt = (state_nxt == OWNED) ? 3'(3'b001 << ptr_nxt) : 3'b000;
    sel_nxt   = (state_nxt == OWNED) ? ptr_nxt : 2'b11;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd2;
      hold_cnt <= 8'd0;
      grant_q  <= 3'b000;
      sel_q    <= 2'b11;
      busy_q   <= 1'b0;
      pre_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      grant_q  <= grant_nxt;
      sel_q    <= sel_nxt;
      busy_q   <= (state_nxt == OWNED);
      pre_q    <= pre_nxt;
    end
  end

  assign bus.grant_out   = grant_q;
  assign bus.sel_out     = sel_q;
  assign bus.busy_out    = busy_q;
  assign bus.preempt_out = pre_q;

endmodule
